riscv_ex_pipe: RTL and testbench



---
 rtl/riscv_ex_pipe.sv | 178 +++++++++++++++++
 tb/tb_riscv_ex_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ex_pipe.sv
// riscv_ex_pipe: RISC-V execute stage with valid/ack handshakes towards ID and MEM.
// Define RISCV_EX_MUL_EN to add the iterative shift-add MUL/MULHU unit (default build: off).
module riscv_ex_pipe #(
    parameter int XLEN   = 32,
    parameter int MEMF_W = 4,
    parameter int SB_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_ex_rdy,
    output logic              id_ex_ack,
    input  logic [11:0]       id_ex_funct,
    input  logic              id_ex_op1_cntl,
    input  logic              id_ex_op2_cntl,
    input  logic [XLEN-1:0]   id_ex_pc,
    input  logic [XLEN-1:0]   id_ex_immed,
    input  logic [XLEN-1:0]   ct_ex_op1,
    input  logic [XLEN-1:0]   ct_ex_op2,
    input  logic [MEMF_W-1:0] id_ex_mem_funct,
    input  logic [SB_W-1:0]   id_ex_mem_sb,
    output logic              ex_mem_rdy,
    input  logic              ex_mem_ack,
    output logic [XLEN-1:0]   ex_mem_result,
    output logic [MEMF_W-1:0] ex_mem_funct,
    output logic [SB_W-1:0]   ex_mem_sb,
    output logic              ex_busy
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [11:0] F_ADD   = 12'h001;
    localparam logic [11:0] F_SUB   = 12'h002;
    localparam logic [11:0] F_OR    = 12'h004;
    localparam logic [11:0] F_XOR   = 12'h008;
    localparam logic [11:0] F_AND   = 12'h010;
    localparam logic [11:0] F_SLT   = 12'h020;
    localparam logic [11:0] F_SLTU  = 12'h040;
    localparam logic [11:0] F_SLL   = 12'h080;
    localparam logic [11:0] F_SRL   = 12'h100;
    localparam logic [11:0] F_SRA   = 12'h200;
    localparam logic [11:0] F_MUL   = 12'h400;
    localparam logic [11:0] F_MULHU = 12'h800;

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   op1, op2, alu_res;
    logic [SH_W-1:0]   shamt;
    logic              slot_free, accept, accept_single;
    logic              start_mul, last_iter, mul_load;
    logic [XLEN-1:0]   mul_res;
    logic [MEMF_W-1:0] mul_funct;
    logic [SB_W-1:0]   mul_sb;

    assign op1       = id_ex_op1_cntl ? id_ex_pc : ct_ex_op1;
    assign op2       = id_ex_op2_cntl ? id_ex_immed : ct_ex_op2;
    assign shamt     = op2[SH_W-1:0];
    assign slot_free = ~ex_mem_rdy | ex_mem_ack;
    assign accept    = id_ex_rdy & id_ex_ack;
    assign accept_single = accept & ~start_mul;

    // NOTE: the default assignment first means every path drives alu_res, so no latch is inferred.
    always_comb begin
        alu_res = '0;
        case (id_ex_funct)
            F_ADD:   alu_res = op1 + op2;
            F_SUB:   alu_res = op1 + ~op2 + XLEN'(1);
            F_OR:    alu_res = op1 | op2;
            F_XOR:   alu_res = op1 ^ op2;
            F_AND:   alu_res = op1 & op2;
            F_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            F_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            F_SLL:   alu_res = op1 << shamt;
            F_SRL:   alu_res = op1 >> shamt;
            F_SRA:   alu_res = XLEN'($signed(op1) >>> shamt);
            default: alu_res = '0;
        endcase
    end

`ifdef RISCV_EX_MUL_EN
    // Accumulator holds {partial high, remaining multiplier bits}; one shift-add per cycle.
    logic [2*XLEN-1:0] acc, acc_nxt, mul_prod;
    logic [XLEN-1:0]   mcand;
    logic [XLEN:0]     psum;
    logic [SH_W-1:0]   cnt;
    logic              mul_hi;
    logic [MEMF_W-1:0] lat_funct;
    logic [SB_W-1:0]   lat_sb;

    assign start_mul = accept & ((id_ex_funct == F_MUL) | (id_ex_funct == F_MULHU));
    assign psum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_nxt   = {psum, acc[XLEN-1:1]};
    assign last_iter = (state == MUL) && (cnt == SH_W'(XLEN-1));
    assign mul_load  = (last_iter | (state == HOLD)) & slot_free;
    assign mul_prod  = (state == HOLD) ? acc : acc_nxt;
    assign mul_res   = mul_hi ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
    assign mul_funct = lat_funct;
    assign mul_sb    = lat_sb;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if ((state == MUL) && !last_iter)
            cnt <= cnt + SH_W'(1);
        else
            cnt <= '0;
    end

    // NOTE: datapath registers carry no reset; they are always loaded at accept before being read.
    always_ff @(posedge clk) begin
        if (start_mul) begin
            acc       <= {{XLEN{1'b0}}, op1};
            mcand     <= op2;
            mul_hi    <= (id_ex_funct == F_MULHU);
            lat_funct <= id_ex_mem_funct;
            lat_sb    <= id_ex_mem_sb;
        end else if (state == MUL) begin
            acc <= acc_nxt;
        end
    end
`else
    assign start_mul = 1'b0;
    assign last_iter = 1'b0;
    assign mul_load  = 1'b0;
    assign mul_res   = '0;
    assign mul_funct = '0;
    assign mul_sb    = '0;
`endif

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_mul) state_nxt = MUL;
            MUL:     if (last_iter) state_nxt = slot_free ? IDLE : HOLD;
            HOLD:    if (slot_free) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        id_ex_ack = (state == IDLE) & slot_free;
`ifdef RISCV_EX_MUL_EN
        ex_busy   = (state != IDLE);
`else
        ex_busy   = 1'b0;
`endif
    end

    // Output slot: a new accept on the same edge as ack replaces the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_rdy    <= 1'b0;
            ex_mem_result <= '0;
            ex_mem_funct  <= '0;
            ex_mem_sb     <= '0;
        end else if (accept_single) begin
            ex_mem_rdy    <= 1'b1;
            ex_mem_result <= alu_res;
            ex_mem_funct  <= id_ex_mem_funct;
            ex_mem_sb     <= id_ex_mem_sb;
        end else if (mul_load) begin
            ex_mem_rdy    <= 1'b1;
            ex_mem_result <= mul_res;
            ex_mem_funct  <= mul_funct;
            ex_mem_sb     <= mul_sb;
        end else if (ex_mem_ack) begin
            ex_mem_rdy    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_ex_pipe.sv
// tb_riscv_ex_pipe: directed and randomized checks of riscv_ex_pipe against a behavioural model.
// Define RISCV_EX_MUL_EN for both files to exercise the multiplier.
module tb_riscv_ex_pipe;
    localparam int XLEN   = 32;
    localparam int MEMF_W = 4;
    localparam int SB_W   = 8;

    localparam logic [11:0] F_ADD  = 12'h001, F_SUB = 12'h002, F_OR  = 12'h004, F_XOR = 12'h008;
    localparam logic [11:0] F_SLT  = 12'h020, F_SLTU = 12'h040, F_SLL = 12'h080, F_SRL = 12'h100;
    localparam logic [11:0] F_SRA  = 12'h200, F_MUL = 12'h400, F_MULHU = 12'h800;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_ex_rdy, id_ex_ack;
    logic [11:0]       id_ex_funct;
    logic              id_ex_op1_cntl, id_ex_op2_cntl;
    logic [XLEN-1:0]   id_ex_pc, id_ex_immed, ct_ex_op1, ct_ex_op2;
    logic [MEMF_W-1:0] id_ex_mem_funct;
    logic [SB_W-1:0]   id_ex_mem_sb;
    logic              ex_mem_rdy, ex_mem_ack;
    logic [XLEN-1:0]   ex_mem_result;
    logic [MEMF_W-1:0] ex_mem_funct;
    logic [SB_W-1:0]   ex_mem_sb;
    logic              ex_busy;

    riscv_ex_pipe #(.XLEN(XLEN), .MEMF_W(MEMF_W), .SB_W(SB_W)) dut (
        .clk(clk), .rst(rst),
        .id_ex_rdy(id_ex_rdy), .id_ex_ack(id_ex_ack), .id_ex_funct(id_ex_funct),
        .id_ex_op1_cntl(id_ex_op1_cntl), .id_ex_op2_cntl(id_ex_op2_cntl),
        .id_ex_pc(id_ex_pc), .id_ex_immed(id_ex_immed),
        .ct_ex_op1(ct_ex_op1), .ct_ex_op2(ct_ex_op2),
        .id_ex_mem_funct(id_ex_mem_funct), .id_ex_mem_sb(id_ex_mem_sb),
        .ex_mem_rdy(ex_mem_rdy), .ex_mem_ack(ex_mem_ack), .ex_mem_result(ex_mem_result),
        .ex_mem_funct(ex_mem_funct), .ex_mem_sb(ex_mem_sb), .ex_busy(ex_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one output slot plus an optional pending multiply.
    bit                m_rdy = 1'b0;
    logic [XLEN-1:0]   m_res = '0;
    logic [MEMF_W-1:0] m_funct = '0;
    logic [SB_W-1:0]   m_sb = '0;
    bit                p_act = 1'b0;
    int                p_cnt = 0;
    logic [XLEN-1:0]   p_res;
    logic [MEMF_W-1:0] p_funct;
    logic [SB_W-1:0]   p_sb;

    function automatic logic [31:0] alu_ref(input logic [11:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned s;
        logic [63:0] p;
        s = b % 32;
        p = {32'b0, a} * {32'b0, b};
        case (f)
            12'h001: return a + b;
            12'h002: return a - b;
            12'h004: return a | b;
            12'h008: return a ^ b;
            12'h010: return a & b;
            12'h020: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            12'h040: return (a < b) ? 32'd1 : 32'd0;
            12'h080: return a << s;
            12'h100: return a >> s;
            12'h200: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
`ifdef RISCV_EX_MUL_EN
            12'h400: return p[31:0];
            12'h800: return p[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_mul_f(input logic [11:0] f);
`ifdef RISCV_EX_MUL_EN
        return (f == F_MUL) || (f == F_MULHU);
`else
        return (f == 12'hFFF) && 1'b0;
`endif
    endfunction

    // One clock: check ack combinationally, advance the model over the edge, check outputs.
    task automatic cycle();
        logic [31:0] a, b, r;
        bit exp_ack, acc, free, ld_mul, mul_op;
        a = id_ex_op1_cntl ? id_ex_pc : ct_ex_op1;
        b = id_ex_op2_cntl ? id_ex_immed : ct_ex_op2;
        r = alu_ref(id_ex_funct, a, b);
        mul_op = is_mul_f(id_ex_funct);
        #1;
        exp_ack = !p_act && (!m_rdy || ex_mem_ack);
        check("id_ex_ack", id_ex_ack, exp_ack);
        free = !m_rdy || ex_mem_ack;
        acc = id_ex_rdy && exp_ack;
        @(posedge clk);
        if (rst) begin
            m_rdy = 0; m_res = '0; m_funct = '0; m_sb = '0; p_act = 0;
        end else begin
            ld_mul = p_act && (p_cnt == 1) && free;
            if (acc && !mul_op) begin
                m_rdy = 1; m_res = r; m_funct = id_ex_mem_funct; m_sb = id_ex_mem_sb;
            end else if (ld_mul) begin
                m_rdy = 1; m_res = p_res; m_funct = p_funct; m_sb = p_sb;
            end else if (ex_mem_ack) begin
                m_rdy = 0;
            end
            if (p_act) begin
                if (p_cnt > 1) p_cnt--;
                else if (free) p_act = 0;
            end
            if (acc && mul_op) begin
                p_act = 1; p_cnt = XLEN; p_res = r; p_funct = id_ex_mem_funct; p_sb = id_ex_mem_sb;
            end
        end
        #1;
        check("ex_mem_rdy", ex_mem_rdy, m_rdy);
        check("ex_busy", ex_busy, p_act);
        if (m_rdy) begin
            check("ex_mem_result", ex_mem_result, m_res);
            check("ex_mem_funct", ex_mem_funct, m_funct);
            check("ex_mem_sb", ex_mem_sb, m_sb);
        end
    endtask

    task automatic issue(input logic [11:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic ack, input logic [7:0] sb);
        id_ex_rdy = 1'b1; id_ex_funct = f;
        id_ex_op1_cntl = 1'b0; id_ex_op2_cntl = 1'b0;
        ct_ex_op1 = a; ct_ex_op2 = b;
        id_ex_mem_funct = 4'(sb); id_ex_mem_sb = sb;
        ex_mem_ack = ack;
        cycle();
    endtask

    task automatic drain();
        id_ex_rdy = 1'b0; ex_mem_ack = 1'b1;
        cycle();
    endtask

    task automatic rand_inputs();
        int sel;
        id_ex_rdy  = ($urandom_range(0, 9) < 7);
        ex_mem_ack = ($urandom_range(0, 9) < 6);
        sel = $urandom_range(0, 15);
        if (sel < 12)       id_ex_funct = 12'h001 << sel;
        else if (sel == 12) id_ex_funct = 12'h000;
        else                id_ex_funct = 12'($urandom);
        id_ex_op1_cntl  = 1'($urandom);
        id_ex_op2_cntl  = 1'($urandom);
        id_ex_pc        = $urandom;
        id_ex_immed     = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
        ct_ex_op1       = $urandom;
        ct_ex_op2       = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
        id_ex_mem_funct = 4'($urandom);
        id_ex_mem_sb    = 8'($urandom);
    endtask

    initial begin
        int lat, busy_cnt;
        rst = 1'b1; id_ex_rdy = 1'b0; ex_mem_ack = 1'b0; id_ex_funct = '0;
        id_ex_op1_cntl = 1'b0; id_ex_op2_cntl = 1'b0; id_ex_pc = '0; id_ex_immed = '0;
        ct_ex_op1 = '0; ct_ex_op2 = '0; id_ex_mem_funct = '0; id_ex_mem_sb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", ex_mem_rdy, 0);
        check("rst_result", ex_mem_result, 0);
        check("rst_funct", ex_mem_funct, 0);
        check("rst_sb", ex_mem_sb, 0);
        check("rst_busy", ex_busy, 0);
        check("rst_ack", id_ex_ack, 1);
        rst = 1'b0;

        // ADD 5 + immediate 3, and PC-relative add
        id_ex_rdy = 1'b1; id_ex_funct = F_ADD; id_ex_op1_cntl = 1'b0; id_ex_op2_cntl = 1'b1;
        ct_ex_op1 = 32'd5; id_ex_immed = 32'd3; id_ex_mem_funct = 4'h9; id_ex_mem_sb = 8'hC3;
        ex_mem_ack = 1'b1;
        cycle();
        check("add_rdy", ex_mem_rdy, 1);
        check("add_imm", ex_mem_result, 32'h0000_0008);
        check("add_sb", ex_mem_sb, 8'hC3);
        id_ex_op1_cntl = 1'b1; id_ex_op2_cntl = 1'b0; id_ex_pc = 32'h100; ct_ex_op2 = 32'd4;
        cycle();
        check("add_pc", ex_mem_result, 32'h0000_0104);

        issue(F_SUB, 32'd3, 32'd5, 1'b1, 8'h11);
        check("sub", ex_mem_result, 32'hFFFF_FFFE);
        issue(F_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 8'h12);
        check("slt", ex_mem_result, 32'd1);
        issue(F_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1, 8'h13);
        check("sltu", ex_mem_result, 32'd0);
        issue(F_SRA, 32'h8000_0000, 32'h24, 1'b1, 8'h14);
        check("sra", ex_mem_result, 32'hF800_0000);
        issue(F_SRL, 32'h8000_0000, 32'h24, 1'b1, 8'h15);
        check("srl", ex_mem_result, 32'h0800_0000);
        issue(F_SLL, 32'd1, 32'd31, 1'b1, 8'h16);
        check("sll", ex_mem_result, 32'h8000_0000);
        issue(12'h003, 32'd7, 32'd9, 1'b1, 8'h17);
        check("non_onehot", ex_mem_result, 32'd0);
        check("non_onehot_sb", ex_mem_sb, 8'h17);
        issue(12'h000, 32'd7, 32'd9, 1'b1, 8'h18);
        check("nop", ex_mem_result, 32'd0);

        // Backpressure: hold for three cycles, then ack+accept on one edge
        drain();
        issue(F_ADD, 32'd10, 32'd20, 1'b0, 8'h21);
        check("bp_first", ex_mem_result, 32'd30);
        for (int i = 0; i < 3; i++) begin
            issue(F_XOR, 32'd1, 32'd2, 1'b0, 8'h22);
            check("bp_hold", ex_mem_result, 32'd30);
            check("bp_hold_sb", ex_mem_sb, 8'h21);
        end
        issue(F_XOR, 32'd7, 32'd1, 1'b1, 8'h23);
        check("bp_replace", ex_mem_result, 32'd6);
        issue(F_OR, 32'd8, 32'd1, 1'b1, 8'h24);
        check("bp_no_bubble", ex_mem_result, 32'd9);
        drain();

`ifdef RISCV_EX_MUL_EN
        issue(F_MULHU, 32'h0001_0000, 32'h0001_0000, 1'b1, 8'hA5);
        id_ex_rdy = 1'b0;
        lat = 1; busy_cnt = 0;
        while (!ex_mem_rdy && lat < 100) begin
            if (ex_busy) busy_cnt++;
            cycle();
            lat++;
        end
        check("mulhu_lat", lat, XLEN + 1);
        check("mulhu_busy", busy_cnt, XLEN);
        check("mulhu_res", ex_mem_result, 32'h0000_0001);
        check("mulhu_sb", ex_mem_sb, 8'hA5);
        drain();
        issue(F_MUL, 32'hFFFF_FFFF, 32'd2, 1'b1, 8'h5A);
        id_ex_rdy = 1'b0;
        lat = 1;
        while (!ex_mem_rdy && lat < 100) begin
            cycle();
            lat++;
        end
        check("mul_lat", lat, XLEN + 1);
        check("mul_res", ex_mem_result, 32'hFFFF_FFFE);
        check("mul_sb", ex_mem_sb, 8'h5A);
        drain();
        issue(F_MUL, 32'h1234_5678, 32'h9, 1'b1, 8'h66);
        id_ex_rdy = 1'b0;
        repeat (10) cycle();
        check("mul_mid_busy", ex_busy, 1);
`else
        issue(F_MUL, 32'h1234_5678, 32'h9, 1'b1, 8'h66);
        check("mul_off_res", ex_mem_result, 32'd0);
        check("mul_off_busy", ex_busy, 0);
        id_ex_rdy = 1'b0; ex_mem_ack = 1'b0;
`endif
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst2_busy", ex_busy, 0);
        check("rst2_rdy", ex_mem_rdy, 0);
        check("rst2_result", ex_mem_result, 0);
        issue(F_ADD, 32'd40, 32'd2, 1'b1, 8'h77);
        check("rst2_add", ex_mem_result, 32'd42);

        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
